// File: rtl/game_pkg.sv
// game_pkg: screen geometry, lane rows and update-FSM encoding shared by the game datapath.
package game_pkg;
  localparam int TILE_SIZE = 32;
  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;
  localparam int C_LINE_1_Y = 96;
  localparam int C_LINE_2_Y = 192;
  localparam int C_LINE_3_Y = 288;
  localparam int C_LINE_4_Y = 384;
  localparam int STEP_W = 3;
  typedef enum logic {IDLE, UPDATE} lane_fsm_t;
endpackage

// File: rtl/lane_mover.sv
// lane_mover: next car X after one step left or right, wrapped into [0, W-1].
module lane_mover import game_pkg::*; #(
  parameter int W = H_VISIBLE_AREA
) (
  input  logic [9:0]        x,
  input  logic [STEP_W-1:0] step,
  input  logic              rev,
  output logic [9:0]        next_x
);
  logic [10:0] t, l;
  always_comb begin
    t = {1'b0, x} + 11'(step);
    l = {1'b0, x} + 11'(W) - 11'(step);
    next_x = rev ? ((x < 10'(step)) ? l[9:0] : x - 10'(step))
                 : ((t >= 11'(W)) ? 10'(t - 11'(W)) : t[9:0]);
  end
endmodule

// File: rtl/car_lane_controller.sv
// car_lane_controller: one vblank-timed motion sweep per frame, one lane per clock, for four car lanes.
module car_lane_controller import game_pkg::*; #(
  parameter int         BASE_STEP    = 1,
  parameter logic [3:0] LANE_REVERSE = 4'b1010,
  parameter int         LANE_DIV_0   = 1,
  parameter int         LANE_DIV_1   = 2,
  parameter int         LANE_DIV_2   = 1,
  parameter int         LANE_DIV_3   = 3,
  parameter int         CAR_INIT_X_0 = 0,
  parameter int         CAR_INIT_X_1 = 160,
  parameter int         CAR_INIT_X_2 = 320,
  parameter int         CAR_INIT_X_3 = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [9:0] i_H_Counter,
  input  logic [9:0] i_V_Counter,
  input  logic       i_Game_Active,
  input  logic [1:0] i_Level,
  input  logic       i_Level_Load,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [3:0] o_Reverse,
  output logic       o_Update_Busy
);
  localparam logic [3:0][3:0] LANE_DIV = {4'(LANE_DIV_3), 4'(LANE_DIV_2), 4'(LANE_DIV_1), 4'(LANE_DIV_0)};
  localparam logic [3:0][9:0] INIT_X = {10'(CAR_INIT_X_3), 10'(CAR_INIT_X_2), 10'(CAR_INIT_X_1), 10'(CAR_INIT_X_0)};
  lane_fsm_t state, state_nx;
  logic [1:0] lane;
  logic [STEP_W-1:0] step;
  logic [3:0][9:0] car_x;
  logic [3:0][3:0] div_cnt;
  logic raw, raw_q, raw_qq, tick, start, hit;
  logic [3:0] lim;
  logic [9:0] moved_x;
  assign raw = (i_V_Counter == 10'(V_VISIBLE_AREA)) && (i_H_Counter == '0);
  assign tick = raw_q && !raw_qq;
  assign start = (state == IDLE) && tick && i_Game_Active && !i_Level_Load;
  assign lim = (LANE_DIV[lane] == '0) ? 4'd1 : LANE_DIV[lane];
  assign hit = ({1'b0, div_cnt[lane]} + 5'd1) >= {1'b0, lim};
  lane_mover #(.W(H_VISIBLE_AREA)) u_mover (
    .x      (car_x[lane]),
    .step   (step),
    .rev    (LANE_REVERSE[lane]),
    .next_x (moved_x)
  );
  always_comb begin
    state_nx = state;
    if (i_Level_Load) state_nx = IDLE;
    else if (start) state_nx = UPDATE;
    else if (state == UPDATE && lane == 2'd3) state_nx = IDLE;
  end
  // load outranks everything, including a sweep already in progress
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= IDLE;
      lane <= '0;
      step <= '0;
      car_x <= INIT_X;
      div_cnt <= '0;
      raw_q <= 1'b0;
      raw_qq <= 1'b0;
    end else begin
      raw_q <= raw;
      raw_qq <= raw_q;
      state <= state_nx;
      if (i_Level_Load) begin
        car_x <= INIT_X;
        div_cnt <= '0;
        lane <= '0;
      end else if (start) begin
        step <= STEP_W'(BASE_STEP) + STEP_W'(i_Level);
        lane <= '0;
      end else if (state == UPDATE) begin
        div_cnt[lane] <= hit ? 4'd0 : div_cnt[lane] + 4'd1;
        if (hit) car_x[lane] <= moved_x;
        lane <= lane + 2'd1;
      end
    end
  end
  assign o_Car_1X_Position = car_x[0];
  assign o_Car_2X_Position = car_x[1];
  assign o_Car_3X_Position = car_x[2];
  assign o_Car_4X_Position = car_x[3];
  assign o_Reverse = LANE_REVERSE;
  assign o_Update_Busy = (state == UPDATE);
endmodule

// File: tb/tb_car_lane_controller.sv
// tb_car_lane_controller: randomized frames against a modular-arithmetic lane model.
module tb_car_lane_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] h = '0, v = '0;
  logic active = 1'b0, load = 1'b0;
  logic [1:0] level = '0;
  logic [9:0] c1, c2, c3, c4;
  logic [3:0] rev;
  logic busy;
  int compared = 0, mismatched = 0;
  int pos[4], nfr[4];
  localparam int DIV[4] = '{1, 2, 1, 3};
  localparam int INIT[4] = '{0, 160, 320, 480};
  localparam int LEFT[4] = '{0, 1, 0, 1};
  car_lane_controller dut (
    .i_Clk(clk), .i_Rst(rst), .i_H_Counter(h), .i_V_Counter(v),
    .i_Game_Active(active), .i_Level(level), .i_Level_Load(load),
    .o_Car_1X_Position(c1), .o_Car_2X_Position(c2), .o_Car_3X_Position(c3), .o_Car_4X_Position(c4),
    .o_Reverse(rev), .o_Update_Busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_cars(input string tag);
    chk({tag, "_x0"}, 32'(c1), pos[0]);
    chk({tag, "_x1"}, 32'(c2), pos[1]);
    chk({tag, "_x2"}, 32'(c3), pos[2]);
    chk({tag, "_x3"}, 32'(c4), pos[3]);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      pos[i] = INIT[i];
      nfr[i] = 0;
    end
  endtask
  task automatic model_frame(input int lvl);
    int s;
    s = 1 + lvl;
    for (int i = 0; i < 4; i++) begin
      nfr[i]++;
      if (nfr[i] % DIV[i] == 0) pos[i] = LEFT[i] ? (pos[i] - s + 640) % 640 : (pos[i] + s) % 640;
    end
  endtask
  task automatic frame(input bit act, input int lvl, input int hold);
    int busy_n, first;
    busy_n = 0;
    first = -1;
    @(negedge clk);
    active = act; level = 2'(lvl); v = 10'd480; h = 10'd0;
    for (int c = 0; c < hold + 8; c++) begin
      @(negedge clk);
      if (c + 1 == hold) begin v = 10'd100; h = 10'd3; end
      if (c == 1) begin level = 2'($urandom_range(0, 3)); active = 1'($urandom_range(0, 1)); end
      if (busy === 1'b1 && first < 0) first = c;
      if (busy === 1'b1) busy_n++;
    end
    chk("busy_cycles", busy_n, act ? 4 : 0);
    if (act) begin
      chk("busy_start", first, 1);
      model_frame(lvl);
    end
    check_cars("frame");
  endtask
  task automatic pulse_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    model_reset();
    check_cars("load");
    chk("load_busy", 32'(busy), 0);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cars("reset");
    chk("reverse", 32'(rev), 32'b1010);
    chk("reset_busy", 32'(busy), 0);
    frame(1, 0, 1);
    chk("f1_x0", 32'(c1), 1);
    chk("f1_x1", 32'(c2), 160);
    chk("f1_x2", 32'(c3), 321);
    chk("f1_x3", 32'(c4), 480);
    repeat (5) frame(1, 0, 1);
    chk("f6_x0", 32'(c1), 6);
    chk("f6_x1", 32'(c2), 157);
    chk("f6_x3", 32'(c4), 478);
    @(negedge clk); #2 rst = 1'b1;
    #1 model_reset();
    check_cars("async_rst");
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk); rst = 1'b0;
    frame(1, 2, 1);
    @(negedge clk); active = 1'b1; v = 10'd480; h = 10'd0;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0; v = 10'd100;
    model_reset();
    check_cars("load_tick");
    chk("load_tick_busy", 32'(busy), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("load_tick_nomove", 32'(busy), 0);
    end
    frame(1, 1, 1);
    @(negedge clk); active = 1'b1; level = 2'd3; v = 10'd480; h = 10'd0;
    @(negedge clk); v = 10'd100;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    model_reset();
    check_cars("load_mid");
    chk("load_mid_busy", 32'(busy), 0);
    repeat (3) frame(0, 1, 2);
    frame(1, 1, 10);
    pulse_load();
    for (int f = 0; f < 159; f++) frame(1, 3, 1);
    frame(1, 2, 1);
    chk("wrap_pre_x0", 32'(c1), 639);
    frame(1, 3, 1);
    chk("wrap_right_x0", 32'(c1), 3);
    for (int f = 0; f < 250; f++) begin
      if ($urandom_range(0, 14) == 0) pulse_load();
      frame($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(1, 10));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
